// File: rtl/mdu_pkg.sv
// Shared types and opcode decode helpers for the EXE-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_HOLD = 3'd4
  } mdu_state_e;

  function automatic logic is_signed(mdu_op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(mdu_op_e op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(mdu_op_e op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring radix-2 divider on operand magnitudes; one quotient bit per cycle,
// sign fixup and divide-by-zero substitution applied combinationally on the outputs.
module mdu_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sgn,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r,
  output logic              valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic              run_q, valid_q, q_neg_q, r_neg_q, dz_q;
  logic [DATA_W-1:0] a_q, dvs_q, quo_q, rem_q;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   shifted, diff;

  assign a_mag   = (sgn & a[DATA_W-1]) ? -a : a;
  assign b_mag   = (sgn & b[DATA_W-1]) ? -b : b;
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else if (start) begin
      cnt_q   <= '0;
      run_q   <= 1'b1;
      valid_q <= 1'b0;
      q_neg_q <= sgn & (a[DATA_W-1] ^ b[DATA_W-1]);
      r_neg_q <= sgn & a[DATA_W-1];
      dz_q    <= (b == '0);
      a_q     <= a;
      dvs_q   <= b_mag;
      quo_q   <= a_mag;
      rem_q   <= '0;
    end else if (run_q) begin
      // A borrow out of the trial subtraction means the divisor did not fit: restore.
      quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
      rem_q <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        run_q   <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign q     = dz_q ? '1  : (q_neg_q ? -quo_q : quo_q);
  assign r     = dz_q ? a_q : (r_neg_q ? -rem_q : rem_q);
  assign valid = valid_q;

endmodule

// File: rtl/exe_mdu_unit.sv
// EXE-stage multiply/divide unit: pipelined multiply/accumulate with MUL_LAT latency and a
// DATA_W+1 cycle divide. Handshake: start is a level held by EXE; done is a one-cycle pulse
// that writes HILO; after done the unit parks in HOLD until stage_adv so no op is relaunched.
module exe_mdu_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                start,
  input  logic                stage_adv,
  input  mdu_op_e             op,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  input  logic [2*DATA_W-1:0] hilo_in,
  output logic                busy,
  output logic                done,
  output logic                stall,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output mdu_state_e          state_dbg
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  mdu_op_e             op_q;
  logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q, div_q, div_r;
  logic [2*DATA_W-1:0] hilo_q, a_ext, b_ext, prod, mul_res, mul_out, res;
  logic                accept, sgn_q, div_valid;

  assign accept = (state_q == ST_IDLE) & start & ~flush;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = is_div(op) ? ST_DIV : ST_MUL;
      ST_MUL: if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
        done    = 1'b1;
        state_d = stage_adv ? ST_IDLE : ST_HOLD;
      end
      ST_DIV: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
      ST_FIX: if (div_valid) begin
        done    = 1'b1;
        state_d = stage_adv ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: if (stage_adv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush cancels everything, including a completion landing in the same cycle.
    if (flush) begin
      state_d = ST_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hilo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == state_q) && ((state_q == ST_MUL) || (state_q == ST_DIV)))
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
      if (accept) begin
        op_q   <= op;
        a_q    <= src_a;
        b_q    <= src_b;
        hilo_q <= hilo_in;
      end
      if (done) begin
        hi_q <= hi_out;
        lo_q <= lo_out;
      end
    end
  end

  assign sgn_q   = is_signed(op_q);
  assign a_ext   = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
  assign b_ext   = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = !is_acc(op_q) ? prod : (is_sub(op_q) ? hilo_q - prod : hilo_q + prod);

  // Operands stay frozen through MUL, so the chain tail is exact when the counter expires.
  generate
    if (MUL_LAT == 1) begin : g_no_pipe
      assign mul_out = mul_res;
    end else begin : g_pipe
      logic [2*DATA_W-1:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= mul_res;
          for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_out = pipe_q[MUL_LAT-2];
    end
  endgenerate

  mdu_div_core #(.DATA_W(DATA_W)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept & is_div(op)),
    .a      (src_a),
    .b      (src_b),
    .sgn    (is_signed(op)),
    .q      (div_q),
    .r      (div_r),
    .valid  (div_valid)
  );

  assign res       = (state_q == ST_FIX) ? {div_r, div_q} : mul_out;
  assign hi_out    = done ? res[2*DATA_W-1:DATA_W] : hi_q;
  assign lo_out    = done ? res[DATA_W-1:0] : lo_q;
  assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX);
  assign stall     = start & ~done & (state_q != ST_HOLD) & ~flush;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exe_mdu_unit.sv
// Directed bench for exe_mdu_unit: vector table of ops with hand-computed results and
// latencies, plus sequences for flush, HOLD, start/flush collision and async reset.
module tb_exe_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush, start, stage_adv;
  mdu_op_e     op;
  logic [31:0] src_a, src_b;
  logic [63:0] hilo_in;
  logic        busy, done, stall;
  logic [31:0] hi_out, lo_out;
  mdu_state_e  state_dbg;

  int errors = 0;
  int checks = 0;

  exe_mdu_unit #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .start     (start),
    .stage_adv (stage_adv),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .hilo_in   (hilo_in),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op, scramble inputs after accept, finish with stage_adv in the done cycle.
  task automatic run_op(input vec_t v, output int lat, output int stall_cnt,
                        output logic [63:0] result);
    @(posedge clk); #1;
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b; hilo_in = v.hilo; stage_adv = 1'b0;
    lat = 0;
    stall_cnt = 0;
    result = '0;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    lat = 1;
    src_a = ~v.a; src_b = ~v.b; hilo_in = ~v.hilo; op = OP_MULTU;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    result = {hi_out, lo_out};
    stage_adv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stage_adv = 1'b0;
  endtask

  initial begin
    int          lat, stall_cnt, cnt;
    logic [63:0] result, prev;
    logic        found;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        64'h0,                   64'hFFFFFFFF_FFFFFFF1, 2};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                   64'hFFFFFFFE_00000001, 2};
    vecs[2]  = '{OP_MSUBU, 32'd2,        32'd3,        64'h0,                   64'hFFFFFFFF_FFFFFFFA, 2};
    vecs[3]  = '{OP_MADD,  32'h7FFFFFFF, 32'd2,        64'h1,                   64'h00000000_FFFFFFFF, 2};
    vecs[4]  = '{OP_MADDU, 32'h10,       32'h10,       64'h00000001_00000000,   64'h00000001_00000100, 2};
    vecs[5]  = '{OP_MSUB,  32'hFFFFFFFF, 32'd1,        64'h0,                   64'h00000000_00000001, 2};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        64'h0,                   64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[7]  = '{OP_DIVU,  32'd9,        32'd0,        64'h0,                   64'h00000009_FFFFFFFF, 33};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h0,                   64'h00000000_80000000, 33};
    vecs[9]  = '{OP_DIVU,  32'd100,      32'd7,        64'h0,                   64'h00000002_0000000E, 33};
    vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h0,                   64'h00000001_FFFFFFFD, 33};
    vecs[11] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        64'h0,                   64'hFFFFFFFB_FFFFFFFF, 33};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd2,        64'h0,                   64'h00000001_7FFFFFFF, 33};

    // Clock/reset
    resetn = 1'b0; flush = 1'b0; start = 1'b0; stage_adv = 1'b0;
    op = OP_MULT; src_a = '0; src_b = '0; hilo_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_done",  64'(done),  64'd0);
    check("reset_hilo",  {hi_out, lo_out}, 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    @(posedge clk); #1;
    resetn = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i], lat, stall_cnt, result);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_stall_cycles", i), 64'(stall_cnt), 64'(vecs[i].lat));
      check($sformatf("vec%0d_hold_after", i), {hi_out, lo_out}, vecs[i].exp);
      check($sformatf("vec%0d_idle_after", i), 64'(state_dbg), 64'(ST_IDLE));
    end
    prev = vecs[12].exp;

    // Flush in the middle of a divide
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    check("flush_mid_state_before", 64'(state_dbg), 64'(ST_DIV));
    flush = 1'b1;
    @(negedge clk);
    check("flush_mid_stall", 64'(stall), 64'd0);
    check("flush_mid_done",  64'(done),  64'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_mid_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("flush_mid_busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("flush_mid_no_done", 64'(cnt), 64'd0);
    check("flush_mid_hilo", {hi_out, lo_out}, prev);

    // Flush landing in the FIX cycle
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (state_dbg == ST_FIX) found = 1'b1;
    end
    check("flush_fix_reached", 64'(found), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_fix_done", 64'(done), 64'd0);
    check("flush_fix_hilo", {hi_out, lo_out}, prev);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_fix_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("flush_fix_hilo_after", {hi_out, lo_out}, prev);

    // start and flush together: nothing accepted
    start = 1'b1; flush = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    check("start_flush_idle", 64'(state_dbg), 64'(ST_IDLE));
    start = 1'b0; flush = 1'b0;

    // Done without stage_adv parks in HOLD; held start must not relaunch
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; src_a = 32'd6; src_b = 32'd7; stage_adv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("hold_done_seen", 64'(found), 64'd1);
    check("hold_result", {hi_out, lo_out}, 64'd42);
    @(posedge clk); #1;
    src_a = 32'd9;
    check("hold_state", 64'(state_dbg), 64'(ST_HOLD));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_stall", i), 64'(stall), 64'd0);
      check($sformatf("hold%0d_done", i), 64'(done), 64'd0);
      check($sformatf("hold%0d_hilo", i), {hi_out, lo_out}, 64'd42);
      check($sformatf("hold%0d_state", i), 64'(state_dbg), 64'(ST_HOLD));
      @(posedge clk); #1;
    end
    stage_adv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stage_adv = 1'b0;
    check("hold_exit_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #3;
    start = 1'b0;
    resetn = 1'b0;
    #1;
    check("async_rst_busy",  64'(busy), 64'd0);
    check("async_rst_done",  64'(done), 64'd0);
    check("async_rst_stall", 64'(stall), 64'd0);
    check("async_rst_hilo",  {hi_out, lo_out}, 64'd0);
    check("async_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
